mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Load/store unit in the MEM stage. It consumes the EX-stage ALU result as the effective address, plus rs2 as store data.
- Drives a request/grant/rvalid data-memory bus.
- Multi-cycle FSM. Stalls the pipeline while an access is outstanding.
- Returns sign- or zero-extended load data for writeback.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, bus data width; fixed at 32, any other value is rejected at elaboration

Ports:
- i_clk  in  1  clock; one clock domain
- i_rst  in  1  synchronous, active-high reset
- i_req_valid_mem  in  1  memory op present in MEM stage
- o_req_ready_mem  out  1  LSU accepts op this cycle
- i_alu_data_mem  in  32  effective address from EX ALU
- i_rs2_data_mem  in  32  store data
- i_funct3_mem  in  3  width/sign code (RV32I LB/LH/LW/LBU/LHU, SB/SH/SW)
- i_mem_wren_mem  in  1  1=store, 0=load
- o_stall_mem  out  1  hold upstream pipeline
- o_done_mem  out  1  one-cycle pulse: op retired
- o_ld_data_mem  out  32  extended load result; valid with o_done_mem on loads
- o_misaligned_mem  out  1  one-cycle pulse with o_done_mem: access faulted
- o_dmem_req  out  1  bus request
- o_dmem_we  out  1  bus write
- o_dmem_addr  out  32  word-aligned bus address (bits[1:0]=0)
- o_dmem_wdata  out  32  lane-shifted store data
- o_dmem_be  out  4  byte enables
- i_dmem_gnt  in  1  request accepted
- i_dmem_rvalid  in  1  read data valid
- i_dmem_rdata  in  32  read data

Behaviour:
- Reset: state IDLE; all outputs 0.
  - o_req_ready_mem is 1 in IDLE only.
  - o_stall_mem = i_req_valid_mem & ~IDLE, or a pending accept.
- Accept: i_req_valid_mem & o_req_ready_mem captures address, data, funct3 and wren into registers.
- Width decode: funct3[1:0] 00=byte, 01=half, 10/11=word. funct3[2]=1 means zero-extend (loads only).
- Alignment: byte is always aligned. Half needs addr[0]=0. Word needs addr[1:0]=0.
- FSM states: IDLE -> REQ -> (store: IDLE on gnt | load: WAIT) -> IDLE on rvalid.
  - REQ: o_dmem_req held high until i_dmem_gnt. Address, we, wdata and be are stable while req=1.
  - Store: o_done_mem pulses the cycle after gnt.
  - Load: o_done_mem and o_ld_data_mem are registered the cycle after i_dmem_rvalid.
  - Minimum load latency, with gnt in the first REQ cycle and rvalid the next cycle: accept at t0, req at t1, rvalid at t2, done at t3.
- Store lanes: SB replicates byte to all lanes, be=1<<addr[1:0]. SH: be=0011<<addr[1:0]. SW: be=1111.
- Load extract: byte/half selected by addr[1:0], then sign- or zero-extended to 32.
- Misaligned access (feature off):
  - No bus access is made.
  - o_done_mem and o_misaligned_mem pulse the cycle after accept.
  - o_ld_data_mem = 0.
- i_dmem_rvalid or i_dmem_gnt outside REQ/WAIT is ignored.
- Reset mid-operation:
  - FSM returns to IDLE on that edge and o_dmem_req drops.
  - A late rvalid is discarded and no done pulse is generated.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN
- Defined:
  - Misaligned accesses that stay inside one word (e.g. LH at offset 1) take a single access with shifted be.
  - Accesses that cross a word boundary (half at offset 3, word at offset 1-3) use two sequential accesses via added states REQ2/WAIT2.
  - First access is the low word (addr&~3); second is addr+4 aligned, wrapping mod 2^32.
  - Load bytes from both words are merged and then extended. o_done_mem pulses once, after the second completion.
  - o_misaligned_mem is never asserted.
- Undefined: fault behaviour as above; REQ2/WAIT2 are absent.

Decomposition:
- Package lsu_pkg:
  - funct3 width codes (LB..LHU, SB..SW)
  - FSM state enum
  - be-generation and alignment-check functions
- Sub-module lsu_load_align: combinational lane select plus sign/zero extension (and two-word merge under the macro).

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt same cycle -> one bus write: addr 0x100, be 1111, wdata 0xDEADBEEF; done 2 cycles after accept.
- LB addr 0x203, rdata 0x80FF_0000 -> o_ld_data_mem 0xFFFFFF80. Same with LBU -> 0x00000080.
- LH addr 0x102, gnt withheld 3 cycles, rvalid 2 cycles later, rdata 0x1234_5678 -> req held 4 cycles; stall high throughout; result 0x00001234.
- LW addr 0x101, macro off -> no o_dmem_req; misaligned+done pulse at t1. Macro on, words 0x44332211 / 0x88776655 -> two reads at 0x100 and 0x104; result 0x55443322.
- Load in WAIT, assert i_rst one cycle, then rvalid -> no done pulse; FSM IDLE; ready=1.
- SB addr 0x003 data 0x000000AB -> be 1000, wdata 0xABABABAB.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM states, lane helpers.
// REQ2/WAIT2 states exist only when LSU_MISALIGNED_SPLIT_EN is defined.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
`ifdef LSU_MISALIGNED_SPLIT_EN
        , ST_REQ2
        , ST_WAIT2
`endif
    } lsu_state_e;

    // Byte enables for the low (hi_word=0) or following (hi_word=1) bus word.
    function automatic logic [3:0] lsu_be(input logic [2:0] f3, input logic [1:0] off,
                                          input logic hi_word);
        logic [7:0] m;
        case (f3[1:0])
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            default: m = 8'h0F;
        endcase
        m = m << off;
        return hi_word ? m[7:4] : m[3:0];
    endfunction

    function automatic logic lsu_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return ~off[0];
            default: return (off == 2'b00);
        endcase
    endfunction

    function automatic logic lsu_crosses(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return (off == 2'b11);
            default: return (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data lane select and sign/zero extension; merges two bus words when
// LSU_MISALIGNED_SPLIT_EN is defined.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rdata_lo,
`ifdef LSU_MISALIGNED_SPLIT_EN
    input  logic [31:0] i_rdata_hi,
`endif
    output logic [31:0] o_data
);

    logic [31:0] w_sh;

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign w_sh = 32'({i_rdata_hi, i_rdata_lo} >> {i_off, 3'b000});
`else
    assign w_sh = i_rdata_lo >> {i_off, 3'b000};
`endif

    always_comb begin
        o_data = w_sh;
        case (i_funct3[1:0])
            2'b00:   o_data = i_funct3[2] ? {24'h0, w_sh[7:0]} : {{24{w_sh[7]}}, w_sh[7:0]};
            2'b01:   o_data = i_funct3[2] ? {16'h0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
            default: o_data = w_sh;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit driving a req/gnt/rvalid data bus.
// Optional LSU_MISALIGNED_SPLIT_EN splits word-crossing accesses instead of faulting them.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid_mem,
    output logic              o_req_ready_mem,
    input  logic [ADDR_W-1:0] i_alu_data_mem,
    input  logic [31:0]       i_rs2_data_mem,
    input  logic [2:0]        i_funct3_mem,
    input  logic              i_mem_wren_mem,
    output logic              o_stall_mem,
    output logic              o_done_mem,
    output logic [31:0]       o_ld_data_mem,
    output logic              o_misaligned_mem,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [DATA_W-1:0] o_dmem_wdata,
    output logic [3:0]        o_dmem_be,
    input  logic              i_dmem_gnt,
    input  logic              i_dmem_rvalid,
    input  logic [DATA_W-1:0] i_dmem_rdata
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("mem_lsu: DATA_W must be 32");
    end

    lsu_state_e        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_funct3;
    logic              r_wren;
    logic              r_done, r_mis;
    logic [31:0]       r_ld_data;
    logic              w_idle, w_accept, w_fault, w_retire, w_ld_fin, w_req, w_hi;
    logic [31:0]       w_ld_ext, w_lo_in, w_repl, w_wdata;
    logic [ADDR_W-1:0] w_addr;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic              r_cross, w_lo_cap;
    logic [31:0]       r_lo;
    logic [63:0]       w_wide;
`endif

    assign w_idle          = (r_state == ST_IDLE);
    assign o_req_ready_mem = w_idle;
    // The op held in MEM during its done cycle is the one retiring, so it must not re-accept.
    assign w_accept        = i_req_valid_mem & w_idle & ~r_done;
    assign o_stall_mem     = i_req_valid_mem & ~r_done;
`ifdef LSU_MISALIGNED_SPLIT_EN
    assign w_fault = 1'b0;
`else
    assign w_fault = w_accept & ~lsu_aligned(i_funct3_mem, i_alu_data_mem[1:0]);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_ld_fin    = 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
        w_lo_cap    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: if (w_accept && !w_fault) w_state_nxt = ST_REQ;
            ST_REQ: if (i_dmem_gnt) begin
                if (!r_wren) w_state_nxt = ST_WAIT;
`ifdef LSU_MISALIGNED_SPLIT_EN
                else if (r_cross) w_state_nxt = ST_REQ2;
`endif
                else begin
                    w_state_nxt = ST_IDLE;
                    w_retire    = 1'b1;
                end
            end
            ST_WAIT: if (i_dmem_rvalid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                if (r_cross) begin
                    w_state_nxt = ST_REQ2;
                    w_lo_cap    = 1'b1;
                end else
`endif
                begin
                    w_state_nxt = ST_IDLE;
                    w_retire    = 1'b1;
                    w_ld_fin    = 1'b1;
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            ST_REQ2: if (i_dmem_gnt) begin
                if (r_wren) begin
                    w_state_nxt = ST_IDLE;
                    w_retire    = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT2;
                end
            end
            ST_WAIT2: if (i_dmem_rvalid) begin
                w_state_nxt = ST_IDLE;
                w_retire    = 1'b1;
                w_ld_fin    = 1'b1;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_funct3  <= '0;
            r_wren    <= 1'b0;
            r_done    <= 1'b0;
            r_mis     <= 1'b0;
            r_ld_data <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            r_cross   <= 1'b0;
            r_lo      <= '0;
`endif
        end else begin
            r_done <= w_retire | w_fault;
            r_mis  <= w_fault;
            if (w_accept) begin
                r_addr   <= i_alu_data_mem;
                r_wdata  <= i_rs2_data_mem;
                r_funct3 <= i_funct3_mem;
                r_wren   <= i_mem_wren_mem;
`ifdef LSU_MISALIGNED_SPLIT_EN
                r_cross  <= lsu_crosses(i_funct3_mem, i_alu_data_mem[1:0]);
`endif
            end
            if (w_fault)       r_ld_data <= '0;
            else if (w_ld_fin) r_ld_data <= w_ld_ext;
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (w_lo_cap) r_lo <= i_dmem_rdata;
`endif
        end
    end

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_repl = {4{r_wdata[7:0]}};
            2'b01:   w_repl = {2{r_wdata[15:0]}};
            default: w_repl = r_wdata;
        endcase
    end

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign w_req   = (r_state == ST_REQ) | (r_state == ST_REQ2);
    assign w_hi    = (r_state == ST_REQ2);
    assign w_wide  = {32'h0, r_wdata} << {r_addr[1:0], 3'b000};
    assign w_wdata = (r_funct3[1:0] == 2'b00) ? w_repl : (w_hi ? w_wide[63:32] : w_wide[31:0]);
    assign w_addr  = {r_addr[ADDR_W-1:2], 2'b00} + (w_hi ? ADDR_W'(4) : '0);
    assign w_lo_in = r_cross ? r_lo : i_dmem_rdata;
`else
    assign w_req   = (r_state == ST_REQ);
    assign w_hi    = 1'b0;
    assign w_wdata = w_repl;
    assign w_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_lo_in = i_dmem_rdata;
`endif

    assign o_dmem_req   = w_req;
    assign o_dmem_we    = w_req & r_wren;
    assign o_dmem_addr  = w_req ? w_addr : '0;
    assign o_dmem_wdata = w_req ? w_wdata : '0;
    assign o_dmem_be    = w_req ? lsu_be(r_funct3, r_addr[1:0], w_hi) : '0;

    lsu_load_align u_load_align (
        .i_funct3   (r_funct3),
        .i_off      (r_addr[1:0]),
        .i_rdata_lo (w_lo_in),
`ifdef LSU_MISALIGNED_SPLIT_EN
        .i_rdata_hi (i_dmem_rdata),
`endif
        .o_data     (w_ld_ext)
    );

    assign o_done_mem       = r_done;
    assign o_misaligned_mem = r_mis;
    assign o_ld_data_mem    = r_ld_data;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed, table-driven bench for mem_lsu with hand-written reset and split-access sequences.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, ready, wren, stall, done, mis;
    logic [31:0] alu, rs2, ld;
    logic [2:0]  f3;
    logic        req, we, gnt, rvalid;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid_mem(valid), .o_req_ready_mem(ready),
        .i_alu_data_mem(alu), .i_rs2_data_mem(rs2), .i_funct3_mem(f3), .i_mem_wren_mem(wren),
        .o_stall_mem(stall), .o_done_mem(done), .o_ld_data_mem(ld), .o_misaligned_mem(mis),
        .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(addr), .o_dmem_wdata(wdata),
        .o_dmem_be(be), .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata)
    );

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr, data, rdata;
        int          gd, rd, lat, reqs;
        logic [3:0]  be;
        logic [31:0] wd, ld;
        bit          mis;
    } vec_t;

    vec_t tab[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  k, nreq, since;
        bit  granted, done_seen, stall_ok;
        string p;
        p = $sformatf("v%0d", idx);
        tick();
        valid = 1'b1; alu = v.addr; rs2 = v.data; f3 = v.f3; wren = v.st;
        #1;
        chk({p, " stall_at_accept"}, 32'(stall), 32'd1);
        k = 0; nreq = 0; since = 0; granted = 0; done_seen = 0; stall_ok = 1;
        for (int c = 1; c <= 40 && !done_seen; c++) begin
            tick();
            gnt = 1'b0; rvalid = 1'b0; rdata = '0;
            if (done) begin
                done_seen = 1; k = c;
            end else begin
                if (!stall) stall_ok = 0;
                if (req) begin
                    nreq++;
                    if (nreq == 1) begin
                        chk({p, " addr"}, addr, {v.addr[31:2], 2'b00});
                        chk({p, " we"}, 32'(we), 32'(v.st));
                        if (v.st) begin
                            chk({p, " be"}, 32'(be), 32'(v.be));
                            chk({p, " wdata"}, wdata, v.wd);
                        end
                    end
                    if (nreq - 1 == v.gd) begin
                        gnt = 1'b1; granted = 1; since = 0;
                    end
                end else if (granted && !v.st) begin
                    if (since == v.rd) begin
                        rvalid = 1'b1; rdata = v.rdata;
                    end
                    since++;
                end
            end
        end
        chk({p, " done_seen"}, 32'(done_seen), 32'd1);
        chk({p, " latency"}, 32'(k), 32'(v.lat));
        chk({p, " req_cycles"}, 32'(nreq), 32'(v.reqs));
        chk({p, " stall_held"}, 32'(stall_ok), 32'd1);
        chk({p, " misaligned"}, 32'(mis), 32'(v.mis));
        if (!v.st || v.mis) chk({p, " ld_data"}, ld, v.ld);
        valid = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    endtask

    initial begin
        //             st  f3      addr          data          rdata         gd rd lat reqs be     wd            ld            mis
        tab[0]  = '{1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 0, 2, 1, 4'hF, 32'hDEAD_BEEF, 32'h0,        0};
        tab[1]  = '{0, 3'b000, 32'h0000_0203, 32'h0,         32'h80FF_0000, 0, 0, 3, 1, 4'h0, 32'h0,        32'hFFFF_FF80, 0};
        tab[2]  = '{0, 3'b100, 32'h0000_0203, 32'h0,         32'h80FF_0000, 0, 0, 3, 1, 4'h0, 32'h0,        32'h0000_0080, 0};
        tab[3]  = '{0, 3'b001, 32'h0000_0102, 32'h0,         32'h1234_5678, 3, 1, 7, 4, 4'h0, 32'h0,        32'h0000_1234, 0};
        tab[4]  = '{0, 3'b010, 32'h0000_0101, 32'h0,         32'h0,         0, 0, 1, 0, 4'h0, 32'h0,        32'h0,         1};
        tab[5]  = '{1, 3'b000, 32'h0000_0003, 32'h0000_00AB, 32'h0,        0, 0, 2, 1, 4'h8, 32'hABAB_ABAB, 32'h0,        0};
        tab[6]  = '{1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h0,        2, 0, 4, 3, 4'hC, 32'hBEEF_BEEF, 32'h0,        0};
        tab[7]  = '{0, 3'b101, 32'h0000_0102, 32'h0,         32'h8001_0000, 0, 0, 3, 1, 4'h0, 32'h0,        32'h0000_8001, 0};
        tab[8]  = '{0, 3'b001, 32'h0000_0102, 32'h0,         32'h8001_0000, 0, 0, 3, 1, 4'h0, 32'h0,        32'hFFFF_8001, 0};
        tab[9]  = '{0, 3'b010, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, 1, 2, 6, 2, 4'h0, 32'h0,        32'hCAFE_F00D, 0};
        tab[10] = '{0, 3'b001, 32'h0000_0101, 32'h0,         32'h0,         0, 0, 1, 0, 4'h0, 32'h0,        32'h0,         1};
        tab[11] = '{1, 3'b010, 32'h0000_0102, 32'hDEAD_BEEF, 32'h0,        0, 0, 1, 0, 4'h0, 32'h0,        32'h0,         1};
        tab[12] = '{0, 3'b000, 32'h0000_0000, 32'h0,         32'h0000_007F, 0, 0, 3, 1, 4'h0, 32'h0,        32'h0000_007F, 0};
        tab[13] = '{0, 3'b100, 32'h0000_0001, 32'h0,         32'h0000_FF00, 0, 0, 3, 1, 4'h0, 32'h0,        32'h0000_00FF, 0};
        tab[14] = '{0, 3'b000, 32'h0000_0001, 32'h0,         32'h0000_FF00, 0, 0, 3, 1, 4'h0, 32'h0,        32'hFFFF_FFFF, 0};

        rst = 1'b1; valid = 1'b0; alu = '0; rs2 = '0; f3 = '0; wren = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst mis", 32'(mis), 32'd0);
        chk("rst req", 32'(req), 32'd0);
        chk("rst we", 32'(we), 32'd0);
        chk("rst addr", addr, 32'd0);
        chk("rst wdata", wdata, 32'd0);
        chk("rst be", 32'(be), 32'd0);
        chk("rst ld", ld, 32'd0);

        for (int i = 0; i < 15; i++) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (tab[i].mis) continue;
`endif
            run_vec(tab[i], i);
        end

        // Stray bus handshakes while idle must not start or retire anything.
        tick();
        gnt = 1'b1; rvalid = 1'b1; rdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_stray done", 32'(done), 32'd0);
            chk("idle_stray req", 32'(req), 32'd0);
        end
        gnt = 1'b0; rvalid = 1'b0;

        // Reset while waiting for rvalid; the late rvalid must be dropped.
        tick();
        valid = 1'b1; alu = 32'h0000_0100; f3 = 3'b010; wren = 1'b0;
        tick();
        chk("rstmid req", 32'(req), 32'd1);
        gnt = 1'b1;
        tick();
        gnt = 1'b0; valid = 1'b0; rst = 1'b1;
        chk("rstmid in_wait ready", 32'(ready), 32'd0);
        tick();
        rst = 1'b0; rvalid = 1'b1; rdata = 32'h1111_1111;
        chk("rstmid ready", 32'(ready), 32'd1);
        chk("rstmid req_drop", 32'(req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            rvalid = 1'b0;
            chk("rstmid no_done", 32'(done), 32'd0);
            chk("rstmid ld", ld, 32'd0);
        end

`ifdef LSU_MISALIGNED_SPLIT_EN
        // Word load at offset 1 spans two bus words.
        tick();
        valid = 1'b1; alu = 32'h0000_0101; f3 = 3'b010; wren = 1'b0;
        tick();
        chk("split req1", 32'(req), 32'd1);
        chk("split addr1", addr, 32'h0000_0100);
        chk("split be1", 32'(be), 32'hE);
        gnt = 1'b1;
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h4433_2211;
        tick();
        rvalid = 1'b0; rdata = '0;
        chk("split req2", 32'(req), 32'd1);
        chk("split addr2", addr, 32'h0000_0104);
        chk("split be2", 32'(be), 32'h1);
        gnt = 1'b1;
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h8877_6655;
        chk("split no_early_done", 32'(done), 32'd0);
        tick();
        rvalid = 1'b0; rdata = '0;
        chk("split done", 32'(done), 32'd1);
        chk("split mis", 32'(mis), 32'd0);
        chk("split ld", ld, 32'h5544_3322);
        valid = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
